simt_scheduler: RTL

Per-core control-flow scheduler with branch-divergence support: sequences the FETCH → DECODE → REQUEST → WAIT → EXECUTE → UPDATE loop for one block, keeps a private PC per thread lane, and issues each instruction to the subset of threads sharing the minimum live PC. Divergent lanes reconverge automatically when their PCs become equal again. It drives the fetcher, the decoder, and the per-lane ALU/LSU/PC units of a compute core, and reports block completion to the dispatcher.

---
 rtl/states_pkg.sv | 29 ++
 rtl/simt_scheduler_min_pc_select.sv | 29 ++
 rtl/simt_scheduler.sv | 129 ++++++++++++
 3 files changed

// File: rtl/states_pkg.sv
// Shared state encodings for the core control path: core sequencing,
// fetcher handshake and per-lane LSU status.
package states_pkg;

    typedef enum logic [2:0] {
        CORE_IDLE = 3'd0,
        FETCH     = 3'd1,
        DECODE    = 3'd2,
        REQUEST   = 3'd3,
        WAIT      = 3'd4,
        EXECUTE   = 3'd5,
        UPDATE    = 3'd6,
        CORE_DONE = 3'd7
    } core_state_t;

    typedef enum logic [2:0] {
        FETCHER_IDLE = 3'd0,
        FETCHING     = 3'd1,
        FETCHED      = 3'd2
    } fetcher_state_t;

    typedef enum logic [1:0] {
        LSU_IDLE   = 2'd0,
        REQUESTING = 2'd1,
        WAITING    = 2'd2,
        LSU_DONE   = 2'd3
    } lsu_state_t;

endpackage

// File: rtl/simt_scheduler_min_pc_select.sv
// Combinational min-PC group selection: finds the smallest candidate PC among
// live lanes and marks every live lane sharing it, so equal PCs merge.
module min_pc_select #(
    parameter int THREADS_PER_BLOCK = 4,
    parameter int PC_WIDTH          = 8
) (
    input  logic [THREADS_PER_BLOCK*PC_WIDTH-1:0] cand_pc,
    input  logic [THREADS_PER_BLOCK-1:0]          live,
    output logic [PC_WIDTH-1:0]                   min_pc,
    output logic [THREADS_PER_BLOCK-1:0]          eq_mask,
    output logic                                  any_live
);

    // Unsigned minimum scan, then tie detection against the winner
    always_comb begin
        min_pc   = '0;
        any_live = 1'b0;
        eq_mask  = '0;
        for (int i = 0; i < THREADS_PER_BLOCK; i++) begin
            min_pc   = (live[i] && (!any_live || (cand_pc[i*PC_WIDTH +: PC_WIDTH] < min_pc)))
                       ? cand_pc[i*PC_WIDTH +: PC_WIDTH] : min_pc;
            any_live = any_live | live[i];
        end
        for (int i = 0; i < THREADS_PER_BLOCK; i++) begin
            eq_mask[i] = live[i] && (cand_pc[i*PC_WIDTH +: PC_WIDTH] == min_pc);
        end
    end

endmodule

// File: rtl/simt_scheduler.sv
// Per-core SIMT control-flow scheduler: runs the fetch/decode/execute loop for
// one block and issues each instruction to the lanes sharing the lowest PC.
module simt_scheduler
    import states_pkg::*;
#(
    parameter int THREADS_PER_BLOCK = 4,
    parameter int PC_WIDTH          = 8
) (
    input  logic                                  clk,
    input  logic                                  reset,
    input  logic                                  start,
    input  logic [$clog2(THREADS_PER_BLOCK):0]    thread_count,
    input  logic                                  decoded_mem_read_enable,
    input  logic                                  decoded_mem_write_enable,
    input  logic                                  decoded_ret,
    input  logic [2:0]                            fetcher_state,
    input  logic [2*THREADS_PER_BLOCK-1:0]        lsu_state,
    input  logic [PC_WIDTH*THREADS_PER_BLOCK-1:0] next_pc,
    output logic [PC_WIDTH-1:0]                   current_pc,
    output logic [THREADS_PER_BLOCK-1:0]          active_mask,
    output logic [2:0]                            core_state,
    output logic                                  diverged,
    output logic                                  done
);

    localparam int CW = $clog2(THREADS_PER_BLOCK) + 1;

    core_state_t                          state;
    logic [THREADS_PER_BLOCK-1:0]         live;
    logic [PC_WIDTH-1:0]                  thread_pc [THREADS_PER_BLOCK];
    logic [THREADS_PER_BLOCK*PC_WIDTH-1:0] cand_pc;
    logic [THREADS_PER_BLOCK-1:0]         sel_live;
    logic [THREADS_PER_BLOCK-1:0]         init_live;
    logic [THREADS_PER_BLOCK-1:0]         eq_mask;
    logic [PC_WIDTH-1:0]                  min_pc;
    logic                                 any_live;
    logic                                 lsu_busy;
    logic                                 mem_op;
    logic                                 wait_clear;

    assign core_state = state;

    // Candidate PCs, launch mask, and LSU stall from active lanes only
    always_comb begin
        cand_pc   = '0;
        init_live = '0;
        lsu_busy  = 1'b0;
        for (int i = 0; i < THREADS_PER_BLOCK; i++) begin
            cand_pc[i*PC_WIDTH +: PC_WIDTH] = active_mask[i] ? next_pc[i*PC_WIDTH +: PC_WIDTH]
                                                             : thread_pc[i];
            init_live[i] = (CW'(i) < thread_count);
            lsu_busy = lsu_busy | (active_mask[i] &
                       ((lsu_state[2*i +: 2] == REQUESTING) | (lsu_state[2*i +: 2] == WAITING)));
        end
        sel_live = decoded_ret ? (live & ~active_mask) : live;
        // Memory flags do not shorten or extend WAIT; the LSU status alone decides.
        mem_op     = decoded_mem_read_enable | decoded_mem_write_enable;
        wait_clear = mem_op ? !lsu_busy : !lsu_busy;
    end

    min_pc_select #(
        .THREADS_PER_BLOCK (THREADS_PER_BLOCK),
        .PC_WIDTH          (PC_WIDTH)
    ) u_min_pc_select (
        .cand_pc  (cand_pc),
        .live     (sel_live),
        .min_pc   (min_pc),
        .eq_mask  (eq_mask),
        .any_live (any_live)
    );

    // Scheduler FSM, per-lane PC/live registers and registered outputs
    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= CORE_IDLE;
            current_pc  <= '0;
            active_mask <= '0;
            diverged    <= 1'b0;
            done        <= 1'b0;
            live        <= '0;
            for (int i = 0; i < THREADS_PER_BLOCK; i++) thread_pc[i] <= '0;
        end else begin
            case (state)
                CORE_IDLE: begin
                    if (start) begin
                        live        <= init_live;
                        current_pc  <= '0;
                        active_mask <= init_live;
                        diverged    <= 1'b0;
                        for (int i = 0; i < THREADS_PER_BLOCK; i++) thread_pc[i] <= '0;
                        if (init_live == '0) begin
                            done  <= 1'b1;
                            state <= CORE_DONE;
                        end else begin
                            state <= FETCH;
                        end
                    end
                end
                FETCH:   if (fetcher_state == FETCHED) state <= DECODE;
                DECODE:  state <= REQUEST;
                REQUEST: state <= WAIT;
                WAIT:    if (wait_clear) state <= EXECUTE;
                EXECUTE: state <= UPDATE;
                UPDATE: begin
                    for (int i = 0; i < THREADS_PER_BLOCK; i++) begin
                        if (active_mask[i]) begin
                            if (decoded_ret) live[i] <= 1'b0;
                            else             thread_pc[i] <= next_pc[i*PC_WIDTH +: PC_WIDTH];
                        end
                    end
                    if (!any_live) begin
                        done        <= 1'b1;
                        active_mask <= '0;
                        diverged    <= 1'b0;
                        state       <= CORE_DONE;
                    end else begin
                        current_pc  <= min_pc;
                        active_mask <= eq_mask;
                        diverged    <= |(sel_live & ~eq_mask);
                        state       <= FETCH;
                    end
                end
                CORE_DONE: state <= CORE_DONE;
                default:   state <= CORE_IDLE;
            endcase
        end
    end

endmodule
